// File: rtl/imm_encoder.sv
// imm_encoder: packs a 32-bit immediate into RISC-V I/S/B/J/U fields over a base word.
// Two-stage valid/ready pipeline; define IMM_RANGE_CHECK_EN to add immediate range checking.
module imm_encoder #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_imm,
   input  logic [2:0]       in_ctrl,
   input  logic [31:0]      in_base,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_err,
   output logic [CNT_W-1:0] enc_count,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [2:0] CTRL_I = 3'b000;
   localparam logic [2:0] CTRL_S = 3'b001;
   localparam logic [2:0] CTRL_B = 3'b010;
   localparam logic [2:0] CTRL_J = 3'b011;
   localparam logic [2:0] CTRL_U = 3'b100;

   // stage A holds the raw request; packing is done combinationally from it
   logic        a_valid;
   logic [31:0] a_imm;
   logic [31:0] a_base;
   logic [2:0]  a_ctrl;

   logic        a_load;
   logic        b_load;
   logic        out_fire;
   logic [31:0] pack_instr;
   logic        ctrl_bad;
   logic        range_bad;
   logic        pack_err;

   assign b_load   = a_valid && (!out_valid || out_ready);
   assign in_ready = !a_valid || !out_valid || out_ready;
   assign a_load   = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   always_comb begin
      pack_instr = a_base;
      ctrl_bad   = 1'b0;
      case (a_ctrl)
         CTRL_I: begin
            pack_instr[31:20] = a_imm[11:0];
         end
         CTRL_S: begin
            pack_instr[31:25] = a_imm[11:5];
            pack_instr[11:7]  = a_imm[4:0];
         end
         CTRL_B: begin
            pack_instr[31]    = a_imm[12];
            pack_instr[30:25] = a_imm[10:5];
            pack_instr[11:8]  = a_imm[4:1];
            pack_instr[7]     = a_imm[11];
         end
         CTRL_J: begin
            pack_instr[31]    = a_imm[20];
            pack_instr[30:21] = a_imm[10:1];
            pack_instr[20]    = a_imm[11];
            pack_instr[19:12] = a_imm[19:12];
         end
         CTRL_U: begin
            pack_instr[31:12] = a_imm[31:12];
         end
         default: begin
            ctrl_bad = 1'b1;
         end
      endcase
   end

`ifdef IMM_RANGE_CHECK_EN
   // flag immediates whose dropped bits would change the value on extraction
   always_comb begin
      range_bad = 1'b0;
      case (a_ctrl)
         CTRL_I, CTRL_S: range_bad = (a_imm[31:11] != {21{a_imm[11]}});
         CTRL_B:         range_bad = (a_imm[31:12] != {20{a_imm[12]}}) || a_imm[0];
         CTRL_J:         range_bad = (a_imm[31:20] != {12{a_imm[20]}}) || a_imm[0];
         CTRL_U:         range_bad = (a_imm[11:0] != 12'd0);
         default:        range_bad = 1'b0;
      endcase
   end
`else
   assign range_bad = 1'b0;
`endif

   assign pack_err = ctrl_bad || range_bad;

   always_ff @(posedge clk) begin
      if (reset) begin
         a_valid <= 1'b0;
         a_imm   <= 32'd0;
         a_base  <= 32'd0;
         a_ctrl  <= 3'd0;
      end else if (a_load) begin
         a_valid <= 1'b1;
         a_imm   <= in_imm;
         a_base  <= in_base;
         a_ctrl  <= in_ctrl;
      end else if (b_load) begin
         a_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_instr <= 32'd0;
         out_err   <= 1'b0;
      end else if (b_load) begin
         out_valid <= 1'b1;
         out_instr <= pack_instr;
         out_err   <= pack_err;
      end else if (out_fire) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         enc_count <= '0;
         err_count <= '0;
      end else if (out_fire) begin
         enc_count <= enc_count + CNT_W'(1);
         if (out_err && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
         end
      end
   end

endmodule
